// File: rtl/sap_control_sequencer_if.sv
// Opcode/run inputs and control/ring/halt outputs of the SAP sequencer.
// master drives RUN/OPCODE; slave is the sequencer itself.
interface sap_control_sequencer_if #(
  parameter int OPCODE_WIDTH = 4,
  parameter int T_STATES     = 6
);
  logic                    RUN;
  logic [OPCODE_WIDTH-1:0] OPCODE;
  logic [11:0]             CONTROL;
  logic [T_STATES-1:0]     RING;
  logic                    HALTED;

  modport master (
    output RUN, OPCODE,
    input  CONTROL, RING, HALTED
  );

  modport slave (
    input  RUN, OPCODE,
    output CONTROL, RING, HALTED
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: T-state ring, HLT, RUN gate, Moore control decode.
// Define SAP_SEQ_VARIABLE_CYCLE_EN to wrap the ring after each op's last state.
module sap_control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int T_STATES     = 6
) (
  input  logic CLK,
  input  logic CLR,
  sap_control_sequencer_if.slave bus
);

  localparam logic [T_STATES-1:0] RING_T1  = T_STATES'(1);
  localparam logic [T_STATES-1:0] RING_ALL = '1;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

  localparam logic [11:0] W_IDLE    = 12'h3E3;
  localparam logic [11:0] W_T1      = 12'h5E3;
  localparam logic [11:0] W_T2      = 12'hBE3;
  localparam logic [11:0] W_T3      = 12'h263;
  localparam logic [11:0] W_IR_MAR  = 12'h1A3;
  localparam logic [11:0] W_RAM_A   = 12'h2C3;
  localparam logic [11:0] W_RAM_B   = 12'h2E1;
  localparam logic [11:0] W_ADD_A   = 12'h3C7;
  localparam logic [11:0] W_SUB_A   = 12'h3CF;
  localparam logic [11:0] W_A_OUT   = 12'h3F2;

  logic [T_STATES-1:0] ring;
  logic                halted;
  logic [11:0]         control;
  logic [T_STATES-1:0] wrap_mask;
  logic                is_lda;
  logic                is_add;
  logic                is_sub;
  logic                is_out;
  logic                is_hlt;
  logic                ring_ok;
  logic                at_last;
  logic                do_halt;

  assign is_lda = bus.OPCODE == OP_LDA;
  assign is_add = bus.OPCODE == OP_ADD;
  assign is_sub = bus.OPCODE == OP_SUB;
  assign is_out = bus.OPCODE == OP_OUT;
  assign is_hlt = bus.OPCODE == OP_HLT;

  assign ring_ok = (ring != '0) &&
                   ((ring & (ring - RING_T1)) == '0);
  assign do_halt = ring[3] && is_hlt;

`ifdef SAP_SEQ_VARIABLE_CYCLE_EN
  logic is_nop;

  assign is_nop = !(is_lda || is_add || is_sub ||
                    is_out || is_hlt);

  // Mask covers the op's last state and everything after it, so an
  // opcode change mid-cycle still wraps instead of running on.
  always_comb begin
    wrap_mask = RING_ALL << 5;
    unique case (1'b1)
      is_nop:  wrap_mask = RING_ALL << 2;
      is_out:  wrap_mask = RING_ALL << 3;
      is_lda:  wrap_mask = RING_ALL << 4;
      default: wrap_mask = RING_ALL << 5;
    endcase
  end
`else
  assign wrap_mask = RING_T1 << (T_STATES - 1);
`endif

  assign at_last = (ring & wrap_mask) != '0;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      ring   <= RING_T1;
      halted <= 1'b0;
    end else if (bus.RUN && !halted) begin
      if (do_halt) begin
        ring   <= '0;
        halted <= 1'b1;
      end else if (!ring_ok || at_last) begin
        ring <= RING_T1;
      end else begin
        ring <= ring << 1;
      end
    end
  end

  always_comb begin
    control = W_IDLE;
    if (!halted) begin
      unique case (1'b1)
        ring[0]: control = W_T1;
        ring[1]: control = W_T2;
        ring[2]: control = W_T3;
        ring[3]: begin
          if (is_lda || is_add || is_sub)
            control = W_IR_MAR;
          else if (is_out)
            control = W_A_OUT;
        end
        ring[4]: begin
          if (is_lda)
            control = W_RAM_A;
          else if (is_add || is_sub)
            control = W_RAM_B;
        end
        ring[5]: begin
          if (is_add)
            control = W_ADD_A;
          else if (is_sub)
            control = W_SUB_A;
        end
        default: control = W_IDLE;
      endcase
    end
  end

  assign bus.CONTROL = control;
  assign bus.RING    = ring;
  assign bus.HALTED  = halted;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: 6- and 8-state instances vs a
// step-counter reference model, directed scenarios then random stimulus.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic       run;
  logic [3:0] op;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sap_control_sequencer_if #(.OPCODE_WIDTH(4), .T_STATES(6)) b6 ();
  sap_control_sequencer_if #(.OPCODE_WIDTH(4), .T_STATES(8)) b8 ();

  assign b6.RUN    = run;
  assign b6.OPCODE = op;
  assign b8.RUN    = run;
  assign b8.OPCODE = op;

  sap_control_sequencer #(.OPCODE_WIDTH(4), .T_STATES(6)) u6 (
    .CLK (clk),
    .CLR (clr),
    .bus (b6)
  );

  sap_control_sequencer #(.OPCODE_WIDTH(4), .T_STATES(8)) u8 (
    .CLK (clk),
    .CLR (clr),
    .bus (b8)
  );

  // model: step number (1-based, 0 when halted) per instance
  int mt[2]  = '{1, 1};
  bit mh[2]  = '{0, 0};
  int mlen[2] = '{6, 8};

  function automatic int last_step(int k, logic [3:0] o);
`ifdef SAP_SEQ_VARIABLE_CYCLE_EN
    case (o)
      4'hE:                return 4;
      4'h0:                return 5;
      4'h1, 4'h2, 4'hF:    return 6;
      default:             return 3;
    endcase
`else
    return mlen[k];
`endif
  endfunction

  function automatic logic [11:0] exp_word(int t, bit h, logic [3:0] o);
    if (h) return 12'h3E3;
    case (t)
      1: return 12'h5E3;
      2: return 12'hBE3;
      3: return 12'h263;
      4: begin
        if (o == 4'h0 || o == 4'h1 || o == 4'h2) return 12'h1A3;
        if (o == 4'hE) return 12'h3F2;
      end
      5: begin
        if (o == 4'h0) return 12'h2C3;
        if (o == 4'h1 || o == 4'h2) return 12'h2E1;
      end
      6: begin
        if (o == 4'h1) return 12'h3C7;
        if (o == 4'h2) return 12'h3CF;
      end
      default: ;
    endcase
    return 12'h3E3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic step_model();
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        mt[k] = 1;
        mh[k] = 1'b0;
      end else if (run && !mh[k]) begin
        if (mt[k] == 4 && op == 4'hF) begin
          mh[k] = 1'b1;
          mt[k] = 0;
        end else if (mt[k] >= last_step(k, op)) begin
          mt[k] = 1;
        end else begin
          mt[k] = mt[k] + 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_ring(int k);
    logic [31:0] one;
    one = 32'd1;
    if (mh[k]) return 32'd0;
    return one << (mt[k] - 1);
  endfunction

  task automatic check_all();
    chk("ctl6", 32'(b6.CONTROL), 32'(exp_word(mt[0], mh[0], op)));
    chk("ring6", 32'(b6.RING), exp_ring(0));
    chk("halt6", 32'(b6.HALTED), 32'(mh[0]));
    chk("ctl8", 32'(b8.CONTROL), 32'(exp_word(mt[1], mh[1], op)));
    chk("ring8", 32'(b8.RING), exp_ring(1));
    chk("halt8", 32'(b8.HALTED), 32'(mh[1]));
  endtask

  task automatic tick(input logic c, input logic r, input logic [3:0] o);
    clr = c;
    run = r;
    op  = o;
    @(posedge clk);
    step_model();
    @(negedge clk);
    check_all();
  endtask

  // run one instruction on the 6-state instance back to T1
  task automatic run_instr(input logic [3:0] o);
    int n;
    n = 0;
    do begin
      tick(1'b0, 1'b1, o);
      n++;
    end while (mt[0] != 1 && n < 12);
    chk("instr_done", 32'(n < 12), 32'd1);
  endtask

  int cnt;
  logic [3:0] prog[3];
  int exp_len[3];

  initial begin
    clr = 1'b1;
    run = 1'b0;
    op  = 4'h0;
    @(negedge clk);

    tick(1'b1, 1'b0, 4'h0);
    tick(1'b1, 1'b0, 4'h0);
    chk("rst_ring", 32'(b6.RING), 32'd1);
    chk("rst_ctl", 32'(b6.CONTROL), 32'h5E3);

    run_instr(4'h0);
    run_instr(4'h2);
    run_instr(4'h1);
    run_instr(4'hE);

    // HLT from T4, then ignore RUN/OPCODE until CLR
    tick(1'b1, 1'b0, 4'hF);
    repeat (4) tick(1'b0, 1'b1, 4'hF);
    chk("halted", 32'(b6.HALTED), 32'd1);
    chk("halt_ring", 32'(b6.RING), 32'd0);
    repeat (20) tick(1'b0, 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)));
    chk("halt_ctl", 32'(b8.CONTROL), 32'h3E3);
    tick(1'b1, 1'b0, 4'h0);
    chk("unhalt", 32'(b6.HALTED), 32'd0);
    chk("unhalt_ctl", 32'(b6.CONTROL), 32'h5E3);

    // RUN stalls during ADD fetch
    tick(1'b0, 1'b1, 4'h1);
    tick(1'b0, 1'b0, 4'h1);
    tick(1'b0, 1'b0, 4'h1);
    chk("stall_ctl", 32'(b6.CONTROL), 32'hBE3);
    tick(1'b0, 1'b1, 4'h1);
    chk("stall_t3", 32'(b6.RING), 32'd4);

    // cycle lengths on the 8-state instance
    prog = '{4'hE, 4'h3, 4'h0};
`ifdef SAP_SEQ_VARIABLE_CYCLE_EN
    exp_len = '{4, 3, 5};
`else
    exp_len = '{8, 8, 8};
`endif
    tick(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      cnt = 0;
      do begin
        tick(1'b0, 1'b1, prog[i]);
        cnt++;
      end while (b8.RING !== 8'd1 && cnt < 20);
      chk("cyc_len", 32'(cnt), 32'(exp_len[i]));
    end

    // CLR in T5 of ADD
    tick(1'b1, 1'b0, 4'h1);
    repeat (4) tick(1'b0, 1'b1, 4'h1);
    tick(1'b1, 1'b1, 4'h1);
    chk("abort_ring", 32'(b6.RING), 32'd1);
    chk("abort_ctl", 32'(b6.CONTROL), 32'h5E3);
    repeat (6) tick(1'b0, 1'b1, 4'h1);

    for (int i = 0; i < 600; i++) begin
      tick(1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Parametrised successor to the SAP-1 control matrix: owns the T-state ring counter, decodes the opcode and drives the 12-bit control word.
- Adds the HLT instruction, a single-step RUN gate, a configurable machine-cycle length and optional variable-length machine cycles.
- Sits between the instruction register's opcode nibble and the bus-control pins of PC, MAR, RAM, IR, A, ALU, B and OUT.

Parameters:
- OPCODE_WIDTH, 4: width of OPCODE input; decode compares the low 4 bits, upper bits must be 0 for a match.
- T_STATES, 6: ring length, legal 6..8; states T7..T8 are idle (no-op) states.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- CLR  input  1  synchronous active-high reset.
- RUN  input  1  1 = advance ring each clock; 0 = hold current state (single step).
- OPCODE  input  OPCODE_WIDTH  IR upper nibble, valid from T4 onward.
- CONTROL  output  12  {Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, EA, SU, EU, LBbar, LObar}, bit 11 = Cp.
- RING  output  T_STATES  one-hot T-state, bit 0 = T1; all zeros when halted.
- HALTED  output  1  1 after HLT executes.

Behaviour:
- Opcodes: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF; all others are NOP (fetch only).
- Reset (CLR=1 at posedge, overrides RUN and HLT): RING=T1, HALTED=0, CONTROL=12'h5E3. Reset mid-instruction aborts that instruction with no partial write.
- State registers: ring (one-hot) and halt flag. CONTROL is a Moore decode of RING and OPCODE, valid in the same cycle RING changes.
- Ring advance on posedge when RUN=1 and HALTED=0: T(n) -> T(n+1), and T_STATES -> T1 (wrap). RUN=0: ring holds and CONTROL holds its current decode.
- Fetch, all opcodes:
  - T1 = 12'h5E3 (Ep, LM)
  - T2 = 12'hBE3 (Cp)
  - T3 = 12'h263 (CE, LI)
- Execute:
  - LDA: T4 = 12'h1A3; T5 = 12'h2C3.
  - ADD: T4 = 12'h1A3; T5 = 12'h2E1; T6 = 12'h3C7.
  - SUB: T4 = 12'h1A3; T5 = 12'h2E1; T6 = 12'h3CF.
  - OUT: T4 = 12'h3F2.
  - Every other execute slot, T7..T8 and NOP: idle word 12'h3E3.
- HLT:
  - In T4 with OPCODE=HLT, CONTROL = idle.
  - At the next posedge with RUN=1: HALTED<=1 and RING<=0.
  - While halted: CONTROL=12'h3E3 constantly; RUN and OPCODE are ignored; only CLR exits.
- Simultaneous events:
  - CLR together with HLT in T4: CLR wins.
  - RUN=0 in T4 with HLT: no halt until RUN=1.
- RING is strictly one-hot or all-zero. An illegal ring value (e.g. after an SEU) recovers to T1 on the next advancing edge.

Optional Feature:
- Macro: SAP_SEQ_VARIABLE_CYCLE_EN.
- Defined: the ring wraps to T1 straight after the last active state of each instruction:
  - NOP wraps after T3.
  - OUT wraps after T4.
  - LDA wraps after T5.
  - ADD and SUB wrap after T6.
  - HLT still halts from T4.
  - Extra states beyond T6 are never entered.
- Undefined: every instruction uses the full T_STATES cycle.

Test Plan:
- CLR=1 for 2 cycles, then RUN=1 with OPCODE=LDA from T4 -> CONTROL sequence 5E3, BE3, 263, 1A3, 2C3, 3E3; then RING=T1 and CONTROL=5E3 again.
- OPCODE=SUB, RUN=1, T_STATES=6 -> T5=2E1, T6=3CF; OPCODE=ADD -> T6=3C7; OUT -> T4=3F2 with T5/T6=3E3.
- OPCODE=HLT at T4 -> next cycle HALTED=1, RING=0, CONTROL=3E3 held for 20 cycles regardless of RUN/OPCODE; pulse CLR -> RING=T1, CONTROL=5E3, HALTED=0.
- RUN toggled 1,0,0,1 during ADD fetch -> RING holds T2 (CONTROL=BE3) for the 2 stalled cycles, then reaches T3; no state skipped.
- SAP_SEQ_VARIABLE_CYCLE_EN defined, program OUT,NOP,LDA -> cycle lengths 4, 3, 5 clocks; with the macro undefined and T_STATES=8 -> 8, 8, 8 clocks, T7/T8=3E3.
- CLR asserted in T5 of ADD -> next cycle RING=T1, CONTROL=5E3; LBbar never low after the reset edge.
